data_memory_mmio: RTL and testbench
===================================

Name: data_memory_mmio

Overview:
- Data-memory stage of the single-cycle MIPS core, directly downstream of the datapath.
- Consumes the datapath's ALU output as the address and its register-file write data as store data.
- Returns load data to the datapath's MemtoReg mux in the same cycle.
- Contains word RAM plus a small memory-mapped register window: GPIO output, free-running cycle counter, store counter, and sticky error status.

Parameters:
- DATA_WIDTH, 32, data word width.
- ADDRESS_WIDTH, 32, byte-address width.
- DEPTH, 256, RAM size in words; power of two, at least 4.
- MMIO_BASE, 32'hFFFF_0000, byte base of the 16-byte register window; 16-byte aligned.

Ports:
- CLK, in, 1, rising-edge clock.
- rst, in, 1, synchronous active-high reset.
- A, in, ADDRESS_WIDTH, byte address.
- WD, in, DATA_WIDTH, store data.
- WE, in, 1, store enable (MemWrite).
- RD, out, DATA_WIDTH, load data; combinational.
- GPIO_Out, out, DATA_WIDTH, GPIO register value.
- Err, out, 1, OR of the ERR_STATUS bits.

Behaviour:
- **Clocking and reset**
  - One clock; reset is synchronous and active-high.
  - All state updates on the rising edge of CLK.
  - Reset takes priority over every write.
  - On reset: all RAM words = 0, GPIO = 0, CYCLE_CNT = 0, STORE_CNT = 0, ERR_STATUS = 0.
  - Consequently GPIO_Out = 0, Err = 0, and RD = 0 for any RAM address.
- **Address decode, using A with the low two bits ignored for region selection**
  - RAM: A < DEPTH*4; word index = A[log2(DEPTH)+1:2].
  - MMIO: MMIO_BASE <= A <= MMIO_BASE+15; offset = A[3:2].
  - Anything else is out-of-range.
- **MMIO map**
  - 0: GPIO, read/write.
  - 1: CYCLE_CNT, read-only.
  - 2: STORE_CNT, read-only.
  - 3: ERR_STATUS, write-1-to-clear, bits [2:0]; upper bits read 0.
- **Reads**
  - Combinational; no WE qualifier.
  - RAM and MMIO reads ignore A[1:0], so a misaligned read returns the containing word and sets no flag.
  - Out-of-range read: RD = 0, no flag.
  - A read in the same cycle as a write to the same location returns the old value; the new value is visible the cycle after the edge.
- **Writes** (WE = 1, rst = 0)
  - A[1:0] != 0: write dropped, ERR bit0 set (misaligned store). Applies in both RAM and MMIO.
  - Aligned RAM: word updated at the edge; STORE_CNT increments, saturating at all-ones.
  - Aligned GPIO: GPIO <= WD.
  - Aligned CYCLE_CNT or STORE_CNT: write dropped, ERR bit2 set (write to read-only register).
  - Aligned ERR_STATUS: for each bit i, bit i is cleared where WD[i] = 1.
  - Out-of-range: write dropped, ERR bit1 set.
  - STORE_CNT counts RAM stores only.
- **CYCLE_CNT**
  - Increments by 1 on every edge while rst = 0.
  - Wraps from all-ones to 0.
  - A read returns the value before the edge.
- **ERR_STATUS**
  - Sticky; cleared only by reset or by W1C.
  - When a set and a clear hit the same bit in the same cycle, set wins. This cannot arise from a single access (a W1C write is itself error-free) and is stated for completeness.
- **Err** is registered-state derived, equal to the OR of ERR_STATUS[2:0]; it rises the cycle after the faulting edge.
- **Reset mid-store:** with rst = 1 and WE = 1, nothing is written; reset values apply.
- **WE = 0:** no state changes except CYCLE_CNT.

Test Plan:
- **Reset:** hold rst 2 cycles with WE = 1, A = 0x10, WD = 0xDEAD_BEEF. Release, read A = 0x10.
  - -> RD = 0, GPIO_Out = 0, Err = 0; CYCLE_CNT reads 0 in the first cycle after release and 1 in the next.
- **RAM store/load:** store 0x1234_5678 at A = 0x3FC (last word for DEPTH 256), then read 0x3FC and 0x3FE.
  - -> both return 0x1234_5678.
  - -> STORE_CNT read at MMIO_BASE+8 = 1.
  - -> A read in the store cycle returns 0.
- **Misaligned and out-of-range stores:**
  - Store at A = 0x0000_0006 -> RAM word 1 unchanged, ERR_STATUS = 0x1, Err = 1 the next cycle.
  - Then store at A = 0x0000_0400 -> ERR_STATUS = 0x3.
  - Read at A = 0x0000_0400 -> RD = 0.
- **Read-only protection and W1C:**
  - Store 5 to MMIO_BASE+4 -> CYCLE_CNT unaffected, ERR_STATUS bit2 = 1.
  - Write 0x4 to MMIO_BASE+C -> ERR_STATUS bit2 cleared, other bits retained.
  - Write 0x7 -> ERR_STATUS = 0, Err = 0.
- **GPIO:** store 0xA5A5_0F0F to MMIO_BASE.
  - -> GPIO_Out = 0xA5A5_0F0F from the next cycle; read-back matches; STORE_CNT unchanged.
- **Counter wrap:** force CYCLE_CNT near all-ones by running 2^32 cycles, or use a reduced-width bench build.
  - -> after all-ones the next read is 0.
  - -> STORE_CNT driven to all-ones stays all-ones on further RAM stores.

Source files
------------

// File: rtl/data_memory_mmio.sv
// rtl/data_memory_mmio.sv - MIPS data memory: word RAM plus GPIO/counter/error register window
// Reads are combinational; stores, counters and error flags update on the rising clock edge.
module data_memory_mmio #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH         = 256,
  parameter logic [ADDRESS_WIDTH-1:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0]    WD,
  input  logic                     WE,
  output logic [DATA_WIDTH-1:0]    RD,
  output logic [DATA_WIDTH-1:0]    GPIO_Out,
  output logic                     Err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] RAM_BYTES = ADDRESS_WIDTH'(DEPTH * 4);

  localparam logic [1:0] OFF_GPIO  = 2'd0;
  localparam logic [1:0] OFF_CYCLE = 2'd1;
  localparam logic [1:0] OFF_STORE = 2'd2;
  localparam logic [1:0] OFF_ERR   = 2'd3;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_gpio;
  logic [DATA_WIDTH-1:0] r_cycle_cnt;
  logic [DATA_WIDTH-1:0] r_store_cnt;
  logic [2:0]            r_err;

  logic             w_in_ram;
  logic             w_in_mmio;
  logic             w_aligned;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_off;
  logic             w_we_ram;
  logic             w_we_gpio;
  logic [2:0]       w_err_set;
  logic [2:0]       w_err_clr;

  assign w_in_ram  = (A < RAM_BYTES);
  assign w_in_mmio = (A[ADDRESS_WIDTH-1:4] == MMIO_BASE[ADDRESS_WIDTH-1:4]);
  assign w_aligned = (A[1:0] == 2'b00);
  assign w_idx     = A[IDX_W+1:2];
  assign w_off     = A[3:2];

  assign w_we_ram  = WE && w_in_ram && w_aligned;
  assign w_we_gpio = WE && w_in_mmio && w_aligned && (w_off == OFF_GPIO);

  // bit0 misaligned in a mapped region, bit1 unmapped, bit2 store to a read-only counter
  assign w_err_set[0] = WE && (w_in_ram || w_in_mmio) && !w_aligned;
  assign w_err_set[1] = WE && !w_in_ram && !w_in_mmio;
  assign w_err_set[2] = WE && w_in_mmio && w_aligned &&
                        ((w_off == OFF_CYCLE) || (w_off == OFF_STORE));
  assign w_err_clr    = (WE && w_in_mmio && w_aligned && (w_off == OFF_ERR)) ? WD[2:0] : 3'b000;

  always_ff @(posedge CLK) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_gpio      <= '0;
      r_cycle_cnt <= '0;
      r_store_cnt <= '0;
      r_err       <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 1'b1;
      if (w_we_ram) begin
        r_mem[w_idx] <= WD;
        if (r_store_cnt != '1) begin
          r_store_cnt <= r_store_cnt + 1'b1;
        end
      end
      if (w_we_gpio) begin
        r_gpio <= WD;
      end
      // set beats clear when both touch the same bit
      r_err <= (r_err & ~w_err_clr) | w_err_set;
    end
  end

  always_comb begin
    RD = '0;
    if (w_in_ram) begin
      RD = r_mem[w_idx];
    end else if (w_in_mmio) begin
      case (w_off)
        OFF_GPIO:  RD = r_gpio;
        OFF_CYCLE: RD = r_cycle_cnt;
        OFF_STORE: RD = r_store_cnt;
        default:   RD = {{(DATA_WIDTH-3){1'b0}}, r_err};
      endcase
    end
  end

  assign GPIO_Out = r_gpio;
  assign Err      = |r_err;

endmodule

// File: tb/tb_data_memory_mmio.sv
// tb/tb_data_memory_mmio.sv - directed self-checking bench for data_memory_mmio
// A second narrow instance (4-bit data) exercises counter wrap and store-count saturation.
module tb_data_memory_mmio;

  localparam logic [31:0] MB = 32'hFFFF_0000;

  logic        CLK = 1'b0;
  logic        rst;
  logic [31:0] A, WD, RD, GPIO_Out;
  logic        WE, Err;
  logic [31:0] A1;
  logic [3:0]  WD1, RD1, GPIO_Out1;
  logic        WE1, Err1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 CLK = ~CLK;

  data_memory_mmio dut (
    .CLK(CLK), .rst(rst), .A(A), .WD(WD), .WE(WE),
    .RD(RD), .GPIO_Out(GPIO_Out), .Err(Err)
  );

  data_memory_mmio #(.DATA_WIDTH(4), .ADDRESS_WIDTH(32), .DEPTH(4), .MMIO_BASE(MB)) dut_n (
    .CLK(CLK), .rst(rst), .A(A1), .WD(WD1), .WE(WE1),
    .RD(RD1), .GPIO_Out(GPIO_Out1), .Err(Err1)
  );

  task automatic tick();
    @(posedge CLK);
    #2;
    if (!rst) cyc++;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic we);
    A = a; WD = wd; WE = we;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; A1 = MB + 32'h4; WD1 = 4'h0; WE1 = 1'b0;
    drive(32'h10, 32'hDEAD_BEEF, 1'b1);
    tick(); tick();
    rst = 1'b0; cyc = 0;
    drive(32'h10, 32'h0, 1'b0);
    n_checks++; if (RD !== 32'h0) begin n_fail++; $display("FAIL reset_ram RD=%h exp=%h", RD, 32'h0); end
    n_checks++; if (GPIO_Out !== 32'h0) begin n_fail++; $display("FAIL reset_gpio got=%h exp=%h", GPIO_Out, 32'h0); end
    n_checks++; if (Err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", Err); end
    drive(MB + 32'h4, 32'h0, 1'b0);
    n_checks++; if (RD !== 32'h0) begin n_fail++; $display("FAIL reset_cycle0 RD=%h exp=%h", RD, 32'h0); end
    tick();
    n_checks++; if (RD !== 32'h1) begin n_fail++; $display("FAIL reset_cycle1 RD=%h exp=%h", RD, 32'h1); end
  endtask

  task automatic test_ram();
    drive(32'h3FC, 32'h1234_5678, 1'b1);
    n_checks++; if (RD !== 32'h0) begin n_fail++; $display("FAIL ram_same_cycle RD=%h exp=%h", RD, 32'h0); end
    tick();
    drive(32'h3FC, 32'h0, 1'b0);
    n_checks++; if (RD !== 32'h1234_5678) begin n_fail++; $display("FAIL ram_load RD=%h exp=%h", RD, 32'h1234_5678); end
    drive(32'h3FE, 32'h0, 1'b0);
    n_checks++; if (RD !== 32'h1234_5678) begin n_fail++; $display("FAIL ram_load_misaligned RD=%h exp=%h", RD, 32'h1234_5678); end
    drive(MB + 32'h8, 32'h0, 1'b0);
    n_checks++; if (RD !== 32'h1) begin n_fail++; $display("FAIL ram_store_cnt RD=%h exp=%h", RD, 32'h1); end
    n_checks++; if (Err !== 1'b0) begin n_fail++; $display("FAIL ram_no_err got=%b exp=0", Err); end
  endtask

  task automatic test_bad_stores();
    drive(32'h6, 32'hFFFF_FFFF, 1'b1);
    n_checks++; if (Err !== 1'b0) begin n_fail++; $display("FAIL misalign_err_same_cycle got=%b exp=0", Err); end
    tick();
    drive(32'h4, 32'h0, 1'b0);
    n_checks++; if (RD !== 32'h0) begin n_fail++; $display("FAIL misalign_word1 RD=%h exp=%h", RD, 32'h0); end
    n_checks++; if (Err !== 1'b1) begin n_fail++; $display("FAIL misalign_err got=%b exp=1", Err); end
    drive(MB + 32'hC, 32'h0, 1'b0);
    n_checks++; if (RD !== 32'h1) begin n_fail++; $display("FAIL misalign_status RD=%h exp=%h", RD, 32'h1); end
    drive(32'h400, 32'h1, 1'b1);
    tick();
    drive(MB + 32'hC, 32'h0, 1'b0);
    n_checks++; if (RD !== 32'h3) begin n_fail++; $display("FAIL oor_status RD=%h exp=%h", RD, 32'h3); end
    drive(32'h400, 32'h0, 1'b0);
    n_checks++; if (RD !== 32'h0) begin n_fail++; $display("FAIL oor_read RD=%h exp=%h", RD, 32'h0); end
    drive(MB + 32'h8, 32'h0, 1'b0);
    n_checks++; if (RD !== 32'h1) begin n_fail++; $display("FAIL bad_store_cnt RD=%h exp=%h", RD, 32'h1); end
  endtask

  task automatic test_ro_w1c();
    drive(MB + 32'h4, 32'h5, 1'b1);
    tick();
    drive(MB + 32'h4, 32'h0, 1'b0);
    n_checks++; if (RD !== 32'(cyc)) begin n_fail++; $display("FAIL ro_cycle RD=%h exp=%h", RD, 32'(cyc)); end
    drive(MB + 32'hC, 32'h0, 1'b0);
    n_checks++; if (RD !== 32'h7) begin n_fail++; $display("FAIL ro_status RD=%h exp=%h", RD, 32'h7); end
    drive(MB + 32'hC, 32'h4, 1'b1);
    tick();
    drive(MB + 32'hC, 32'h0, 1'b0);
    n_checks++; if (RD !== 32'h3) begin n_fail++; $display("FAIL w1c_bit2 RD=%h exp=%h", RD, 32'h3); end
    n_checks++; if (Err !== 1'b1) begin n_fail++; $display("FAIL w1c_err_kept got=%b exp=1", Err); end
    drive(MB + 32'hC, 32'h7, 1'b1);
    tick();
    drive(MB + 32'hC, 32'h0, 1'b0);
    n_checks++; if (RD !== 32'h0) begin n_fail++; $display("FAIL w1c_all RD=%h exp=%h", RD, 32'h0); end
    n_checks++; if (Err !== 1'b0) begin n_fail++; $display("FAIL w1c_err_low got=%b exp=0", Err); end
  endtask

  task automatic test_gpio();
    drive(MB, 32'hA5A5_0F0F, 1'b1);
    n_checks++; if (GPIO_Out !== 32'h0) begin n_fail++; $display("FAIL gpio_before_edge got=%h exp=%h", GPIO_Out, 32'h0); end
    tick();
    drive(MB, 32'h0, 1'b0);
    n_checks++; if (GPIO_Out !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL gpio_out got=%h exp=%h", GPIO_Out, 32'hA5A5_0F0F); end
    n_checks++; if (RD !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL gpio_read RD=%h exp=%h", RD, 32'hA5A5_0F0F); end
    drive(MB + 32'h8, 32'h0, 1'b0);
    n_checks++; if (RD !== 32'h1) begin n_fail++; $display("FAIL gpio_store_cnt RD=%h exp=%h", RD, 32'h1); end
    drive(MB + 32'h1, 32'h1111_1111, 1'b1);
    tick();
    drive(MB + 32'hC, 32'h0, 1'b0);
    n_checks++; if (GPIO_Out !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL gpio_misaligned got=%h exp=%h", GPIO_Out, 32'hA5A5_0F0F); end
    n_checks++; if (RD !== 32'h1) begin n_fail++; $display("FAIL gpio_misaligned_status RD=%h exp=%h", RD, 32'h1); end
    drive(MB + 32'hC, 32'h1, 1'b1);
    tick();
  endtask

  task automatic test_back_to_back();
    drive(32'h0, 32'h0000_0011, 1'b1);
    tick();
    drive(32'h4, 32'h0000_0022, 1'b1);
    n_checks++; if (RD !== 32'h0) begin n_fail++; $display("FAIL b2b_old_value RD=%h exp=%h", RD, 32'h0); end
    A = 32'h0; #1;
    n_checks++; if (RD !== 32'h11) begin n_fail++; $display("FAIL b2b_word0_during RD=%h exp=%h", RD, 32'h11); end
    A = 32'h4; #1;
    tick();
    drive(32'h4, 32'h0, 1'b0);
    n_checks++; if (RD !== 32'h22) begin n_fail++; $display("FAIL b2b_word1 RD=%h exp=%h", RD, 32'h22); end
    drive(MB + 32'h8, 32'h0, 1'b0);
    n_checks++; if (RD !== 32'h3) begin n_fail++; $display("FAIL b2b_store_cnt RD=%h exp=%h", RD, 32'h3); end
  endtask

  task automatic test_wrap();
    A1 = MB + 32'h4; WE1 = 1'b0; #1;
    for (int i = 0; i < 20 && (cyc % 16) != 15; i++) tick();
    n_checks++; if (RD1 !== 4'hF) begin n_fail++; $display("FAIL wrap_allones RD=%h exp=%h", RD1, 4'hF); end
    tick();
    n_checks++; if (RD1 !== 4'h0) begin n_fail++; $display("FAIL wrap_zero RD=%h exp=%h", RD1, 4'h0); end
    A1 = 32'h0; WD1 = 4'h9; WE1 = 1'b1; #1;
    for (int i = 0; i < 15; i++) tick();
    WE1 = 1'b0; A1 = MB + 32'h8; #1;
    n_checks++; if (RD1 !== 4'hF) begin n_fail++; $display("FAIL sat_reach RD=%h exp=%h", RD1, 4'hF); end
    A1 = 32'h4; WD1 = 4'h6; WE1 = 1'b1; #1;
    tick(); tick();
    WE1 = 1'b0; A1 = MB + 32'h8; #1;
    n_checks++; if (RD1 !== 4'hF) begin n_fail++; $display("FAIL sat_hold RD=%h exp=%h", RD1, 4'hF); end
    A1 = 32'h4; #1;
    n_checks++; if (RD1 !== 4'h6) begin n_fail++; $display("FAIL sat_store_still_writes RD=%h exp=%h", RD1, 4'h6); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_bad_stores();
    test_ro_w1c();
    test_gpio();
    test_back_to_back();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
